// File: rtl/inst_issue.sv
// inst_issue: two-slot bundle intake, DEPTH-entry circular slot queue,
// single-instruction issue with downstream stall and branch flush.
// Optional build macro: INST_ISSUE_NOP_FILTER_EN (drop Nop slots on intake).
module inst_issue #(
   parameter int          DEPTH  = 4,
   parameter logic [5:0]  NOP_OP = 6'h00
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_from_fetch,
   input  logic [63:0] inst_from_fetch,
   output logic        interlock,
   input  logic        branch_flag,
   input  logic        issue_stall,
   output logic        valid_out,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        slot_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [31:0] IDLE_INST = {NOP_OP, 26'b0};

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        slot;
   } entry_t;

   entry_t [DEPTH-1:0] mem_d, mem_q;
   logic [AW-1:0]      head_d, head_q, tail_d, tail_q, wr_ptr;
   logic [CW-1:0]      count_d, count_q;
   logic               valid_d, valid_q, slot_d, slot_q;
   logic [31:0]        inst_d, inst_q, pc_d, pc_q;
   logic               accept, en0, en1, pop;

   // Interlock leaves room for a full two-slot bundle, so enqueue never overflows.
   assign interlock = (count_q >= CW'(DEPTH - 1));

   assign valid_out = valid_q;
   assign inst_out  = inst_q;
   assign pc_out    = pc_q;
   assign slot_out  = slot_q;

   // Intake qualification: which slots of the offered bundle get enqueued.
   always_comb begin
      accept = !interlock && !branch_flag;
      en0    = accept;
      en1    = accept;
`ifdef INST_ISSUE_NOP_FILTER_EN
      en0    = accept && (inst_from_fetch[63:58] != NOP_OP);
      en1    = accept && (inst_from_fetch[31:26] != NOP_OP);
`endif
   end

   // Next-state for queue storage, pointers, count and output registers.
   always_comb begin
      mem_d  = mem_q;
      wr_ptr = tail_q;
      if (en0) begin
         mem_d[wr_ptr] = '{inst: inst_from_fetch[63:32], pc: pc_from_fetch, slot: 1'b0};
         wr_ptr        = wr_ptr + AW'(1);
      end
      if (en1) begin
         mem_d[wr_ptr] = '{inst: inst_from_fetch[31:0], pc: pc_from_fetch, slot: 1'b1};
      end

      pop     = !issue_stall && (count_q != '0);
      tail_d  = tail_q + AW'(en0) + AW'(en1);
      head_d  = pop ? head_q + AW'(1) : head_q;
      count_d = count_q + CW'(en0) + CW'(en1) - CW'(pop);

      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      slot_d  = slot_q;
      if (pop) begin
         valid_d = 1'b1;
         inst_d  = mem_q[head_q].inst;
         pc_d    = mem_q[head_q].pc;
         slot_d  = mem_q[head_q].slot;
      end else if (!issue_stall) begin
         valid_d = 1'b0;
         inst_d  = IDLE_INST;
         pc_d    = '0;
         slot_d  = 1'b0;
      end

      // Flush wins over stall: empty the queue and present an idle slot.
      if (branch_flag) begin
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
         valid_d = 1'b0;
         inst_d  = IDLE_INST;
         pc_d    = '0;
         slot_d  = 1'b0;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= 1'b0;
         inst_q  <= IDLE_INST;
         pc_q    <= '0;
         slot_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         slot_q  <= slot_d;
      end
   end

   // Slot storage needs no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_inst_issue.sv
// tb_inst_issue: directed scenarios plus random traffic; a queue-based
// reference model predicts every cycle's outputs into a scoreboard that a
// negedge monitor drains and compares.
module tb_inst_issue;

   localparam int         DEPTH  = 4;
   localparam logic [5:0] NOP_OP = 6'h00;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc_from_fetch = '0;
   logic [63:0] inst_from_fetch = '0;
   logic        interlock;
   logic        branch_flag = 1'b0;
   logic        issue_stall = 1'b0;
   logic        valid_out;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        slot_out;

   always #5 clk = ~clk;

   inst_issue #(.DEPTH(DEPTH), .NOP_OP(NOP_OP)) dut (
      .clk(clk), .rstn(rstn), .pc_from_fetch(pc_from_fetch),
      .inst_from_fetch(inst_from_fetch), .interlock(interlock),
      .branch_flag(branch_flag), .issue_stall(issue_stall),
      .valid_out(valid_out), .inst_out(inst_out), .pc_out(pc_out),
      .slot_out(slot_out)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        slot;
   } ent_t;

   typedef struct {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        slot;
      logic        il;
   } exp_t;

   ent_t model_q[$];
   exp_t sb[$];
   exp_t held;
   exp_t idle_e;
   int   total = 0;
   int   bad   = 0;

   function automatic logic keep_slot(input logic [31:0] ins);
`ifdef INST_ISSUE_NOP_FILTER_EN
      return ins[31:26] != NOP_OP;
`else
      return 1'b1;
`endif
   endfunction

   // One clock of stimulus; the model advances and records the expected
   // post-edge output state.
   task automatic step(input logic r, input logic b, input logic s,
                       input logic [31:0] pc, input logic [63:0] bundle);
      logic il;
      ent_t e;
      @(negedge clk);
      #1;
      rstn = r; branch_flag = b; issue_stall = s;
      pc_from_fetch = pc; inst_from_fetch = bundle;
      il = (model_q.size() >= DEPTH - 1);
      if (!r || b) begin
         model_q.delete();
         held = idle_e;
      end else begin
         if (!s) begin
            if (model_q.size() > 0) begin
               e = model_q.pop_front();
               held = '{valid: 1'b1, inst: e.inst, pc: e.pc, slot: e.slot, il: 1'b0};
            end else begin
               held = idle_e;
            end
         end
         if (!il) begin
            if (keep_slot(bundle[63:32])) model_q.push_back('{inst: bundle[63:32], pc: pc, slot: 1'b0});
            if (keep_slot(bundle[31:0]))  model_q.push_back('{inst: bundle[31:0],  pc: pc, slot: 1'b1});
         end
      end
      held.il = (model_q.size() >= DEPTH - 1);
      sb.push_back(held);
      @(posedge clk);
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(3) == 0) v[31:26] = NOP_OP;
      else if (v[31:26] == NOP_OP) v[31:26] = NOP_OP + 6'd1;
      return v;
   endfunction

   // Monitor: every cycle the DUT presents must match the next scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (valid_out !== e.valid || inst_out !== e.inst || pc_out !== e.pc ||
             slot_out !== e.slot || interlock !== e.il) begin
            bad++;
            $display("FAIL out@%0t: got v=%0b inst=%h pc=%h slot=%0b il=%0b want v=%0b inst=%h pc=%h slot=%0b il=%0b",
                     $time, valid_out, inst_out, pc_out, slot_out, interlock,
                     e.valid, e.inst, e.pc, e.slot, e.il);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b2, c;
      logic [63:0] nopb;
      idle_e = '{valid: 1'b0, inst: {NOP_OP, 26'b0}, pc: 32'h0, slot: 1'b0, il: 1'b0};
      held   = idle_e;
      nopb   = {NOP_OP, 26'b0, NOP_OP, 26'b0};
      a  = 32'h1234_5678; b2 = 32'h8765_4321; c = 32'hC0DE_0001;

      // Reset, then a basic two-slot bundle.
      step(0, 0, 0, 32'h0, nopb);
      step(0, 0, 0, 32'h0, nopb);
      step(1, 0, 0, 32'h10, {a, b2});
      for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, nopb);

      // Fill under stall; third bundle held until drain frees room.
      step(0, 0, 0, 32'h0, nopb);
      step(1, 0, 1, 32'h100, {32'h1111_0001, 32'h1111_0002});
      step(1, 0, 1, 32'h104, {32'h2222_0001, 32'h2222_0002});
      for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h108, {32'h3333_0001, 32'h3333_0002});
      for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h108, {32'h3333_0001, 32'h3333_0002});
      for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, nopb);

      // Count=3, then flush under stall.
      step(0, 0, 0, 32'h0, nopb);
      step(1, 0, 1, 32'h200, {32'h4444_0001, 32'h4444_0002});
      step(1, 0, 0, 32'h204, {32'h5555_0001, 32'h5555_0002});
      step(1, 1, 1, 32'h208, {32'h6666_0001, 32'h6666_0002});
      step(1, 0, 1, 32'h0, nopb);
      step(1, 0, 0, 32'h0, nopb);

      // Nop in slot 0 followed by a real instruction.
      step(0, 0, 0, 32'h0, nopb);
      step(1, 0, 0, 32'h20, {NOP_OP, 26'b0, c});
      for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, nopb);

      // Concurrent enqueue/pop with pointer wrap over ten bundles.
      step(0, 0, 0, 32'h0, nopb);
      step(1, 0, 1, 32'h300, {32'h7000_0000, 32'h7000_0001});
      for (int i = 1; i <= 10; i++)
         step(1, 0, 0, 32'h300 + 32'(i * 4), {32'h7000_0000 + 32'(i * 2), 32'h7000_0001 + 32'(i * 2)});
      for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, nopb);

      // Reset mid-operation with a non-empty queue and a live output.
      step(1, 0, 1, 32'h400, {32'h8888_0001, 32'h8888_0002});
      step(1, 0, 0, 32'h404, {32'h9999_0001, 32'h9999_0002});
      step(0, 0, 0, 32'h408, {32'hAAAA_0001, 32'hAAAA_0002});
      for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, nopb);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) >= 2, $urandom_range(99) < 5, $urandom_range(99) < 40,
              $urandom, {rnd_inst(), rnd_inst()});
      end

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_issue.md
INST_ISSUE -- requirements
Module: inst_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-slot queue depth (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port pc_from_fetch  input  32  bundle PC from fetch stage.
REQ-005 SHALL have port inst_from_fetch  input  64  two-slot bundle; slot 0 = [63:32], slot 1 = [31:0].
REQ-006 SHALL have port interlock  output  1  stall request to fetch; bundle not consumed while high.
REQ-007 SHALL have port branch_flag  input  1  redirect/flush from execute.
REQ-008 SHALL have port issue_stall  input  1  downstream hold request.
REQ-009 SHALL have port valid_out  output  1  inst_out carries a real instruction.
REQ-010 SHALL have port inst_out  output  32  issued instruction.
REQ-011 SHALL have port pc_out  output  32  bundle PC of issued instruction.
REQ-012 SHALL have port slot_out  output  1  slot index (0/1) of issued instruction within its bundle.

Function
REQ-013 SHALL hold a circular queue of DEPTH entries {inst[31:0], pc[31:0], slot}, with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-014 SHALL drive interlock combinationally as (count >= DEPTH-1), independent of issue or branch in the same cycle.
REQ-015 SHALL accept the input bundle at a rising edge only if interlock is low, rstn is high and branch_flag is low; otherwise the input is ignored (fetch holds it).
REQ-016 SHALL enqueue accepted slots in order slot 0 then slot 1, each tagged with pc_from_fetch and its slot index; enqueue count 0, 1 or 2 per cycle.
REQ-017 SHALL, when issue_stall is low and count > 0, pop the head into the output registers with valid_out=1.
REQ-018 SHALL, when issue_stall is low and count = 0, load valid_out=0, inst_out={Nop,26'b0}, pc_out=0, slot_out=0.
REQ-019 SHALL hold all output registers and the head pointer unchanged while issue_stall is high.
REQ-020 SHALL support enqueue and pop at the same edge: count_next = count + enq - pop, never exceeding DEPTH or going below 0.
REQ-021 SHALL, when branch_flag is high at an edge, clear count and both pointers, discard the input bundle, and load the REQ-018 idle output values, overriding issue_stall.
REQ-022 SHALL issue at most one instruction per cycle; a slot accepted at edge E is earliest on inst_out after edge E+1.
REQ-023 SHALL preserve program order: slot 0 before slot 1, earlier bundles before later ones.

Reset
REQ-024 SHALL, with rstn low at an edge, set count=0, head=tail=0, valid_out=0, inst_out={Nop,26'b0}, pc_out=0, slot_out=0; interlock reads 0 from the following cycle.
REQ-025 SHALL treat reset as dominant over branch_flag, issue_stall and input acceptance, including mid-operation with a non-empty queue.

Configuration
REQ-026 SHALL, with macro INST_ISSUE_NOP_FILTER_EN defined, drop accepted slots whose [31:26] equals Nop (enqueue 0, 1 or 2 accordingly).
REQ-027 SHALL, without INST_ISSUE_NOP_FILTER_EN, enqueue both slots of every accepted bundle regardless of opcode, issuing Nop slots with valid_out=1.

Verification
REQ-028 SHALL cover: reset, then bundle pc=0x10 with two non-Nop instructions A,B -> A(pc 0x10, slot 0) then B(pc 0x10, slot 1) on consecutive cycles, valid_out=1.
REQ-029 SHALL cover: DEPTH=4, issue_stall held high, three two-slot bundles offered -> interlock high once count=4; third bundle held unaccepted; releasing stall drains 4 entries in order, then third bundle accepted.
REQ-030 SHALL cover: count=3 with branch_flag=1 and issue_stall=1 in the same cycle -> next cycle count=0, valid_out=0, inst_out={Nop,26'b0}, interlock=0.
REQ-031 SHALL cover: with INST_ISSUE_NOP_FILTER_EN, bundle {Nop,26'b0, C} at pc 0x20 -> only C issued, slot_out=1; without macro -> Nop issued (slot 0) then C.
REQ-032 SHALL cover: enqueue of 2 and pop of 1 at the same edge with count=2 -> count=3, interlock asserted, pointers wrap correctly over 10 bundles with no loss or reorder.
REQ-033 SHALL cover: rstn low for one cycle with count=3 and valid_out=1 -> all outputs at reset values next cycle, no stale entry issued afterward.
